// File: rtl/sys_uart_bridge.sv
// -----------------------------------------------------------------------------
// sys_uart_bridge
//
// Board-level serial bridge between the System terminal byte interface and an
// 8N1 UART. Bytes strobed by the terminal are queued in a TX FIFO and
// serialised onto uart_tx. Frames arriving on uart_rx are deserialised, queued
// in an RX FIFO and presented to the terminal on sys_idata.
//
// Handshake semantics (both directions are push/pull, never back-pressured):
//   - sys_odata[8] is a one-cycle "valid" strobe; there is no ready. Every
//     cycle it is high, sys_odata[7:0] is pushed at that edge. If the TX FIFO
//     is full (and no pop happens on the same edge) the byte is dropped and
//     tx_overflow latches.
//   - sys_idata[8] is "valid" (RX FIFO non-empty) and sys_idata[7:0] the head
//     byte (0 when empty). sys_tookdata is the consumer's one-cycle "took"
//     pulse; it pops the head at that edge and is ignored while empty.
//
// Parameters:
//   CLKS_PER_BIT   clk cycles per UART bit (4..65535)
//   TX_DEPTH_LOG2  log2 of the TX FIFO depth
//   RX_DEPTH_LOG2  log2 of the RX FIFO depth
//
// Ports:
//   clk           system clock (single domain)
//   Nrst          asynchronous active-low reset
//   sys_odata     [8] byte strobe, [7:0] byte to transmit
//   sys_idata     [8] RX FIFO non-empty, [7:0] RX FIFO head (registered)
//   sys_tookdata  one-cycle pulse popping the RX head
//   uart_tx       serial output, idle high
//   uart_rx       serial input, asynchronous, idle high
//   tx_overflow   sticky: strobed byte dropped, TX FIFO full
//   rx_overrun    sticky: received byte dropped, RX FIFO full
//   rx_frame_err  sticky: stop bit sampled low
//   tx_state_dbg  current TX FSM state (debug)
//   rx_state_dbg  current RX FSM state (debug)
// -----------------------------------------------------------------------------
module sys_uart_bridge #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       Nrst,
    input  logic [8:0] sys_odata,
    output logic [8:0] sys_idata,
    input  logic       sys_tookdata,
    output logic       uart_tx,
    input  logic       uart_rx,
    output logic       tx_overflow,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic [1:0] tx_state_dbg,
    output logic [1:0] rx_state_dbg
);

    // FSM state encoding, shared by the TX and RX machines.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Bit-period counter holds 0..CLKS_PER_BIT-1.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    // The edge that detects the falling edge already accounts for one cycle of
    // the half-bit wait, so the resample happens CLKS_PER_BIT/2 cycles after
    // the synchronised line was first seen low.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       IDX_ONE   = 3'd1;
    localparam logic [2:0]       IDX_LAST  = 3'd7;

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int TX_CW    = TX_DEPTH_LOG2 + 1;
    localparam logic [TX_CW-1:0]         TX_FULL_CNT = TX_CW'(TX_DEPTH);
    localparam logic [TX_CW-1:0]         TX_CNT_ONE  = TX_CW'(1);
    localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE  = TX_DEPTH_LOG2'(1);

    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int RX_CW    = RX_DEPTH_LOG2 + 1;
    localparam logic [RX_CW-1:0]         RX_FULL_CNT = RX_CW'(RX_DEPTH);
    localparam logic [RX_CW-1:0]         RX_CNT_ONE  = RX_CW'(1);
    localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE  = RX_DEPTH_LOG2'(1);

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    logic [7:0]               tx_mem [TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] tx_wr;
    logic [TX_DEPTH_LOG2-1:0] tx_rd;
    logic [TX_CW-1:0]         tx_count;

    logic [1:0]       tx_state;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_idx;
    logic [7:0]       tx_shift;
    logic             tx_line;

    logic tx_bit_end;
    logic tx_nonempty;
    logic tx_full;
    logic tx_pop;
    logic tx_push;
    logic tx_drop;

    always_comb begin
        tx_bit_end  = (tx_cnt == BIT_LAST);
        tx_nonempty = (tx_count != '0);
        tx_full     = (tx_count == TX_FULL_CNT);
        // Pops happen only when the shifter is free: idle, or the last cycle
        // of a stop bit (back-to-back frames with no idle gap).
        tx_pop      = tx_nonempty &&
                      ((tx_state == ST_IDLE) ||
                       ((tx_state == ST_STOP) && tx_bit_end));
        // A full FIFO that is popping on this edge still has room.
        tx_push     = sys_odata[8] && (!tx_full || tx_pop);
        tx_drop     = sys_odata[8] && tx_full && !tx_pop;
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr] <= sys_odata[7:0];
        end
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            tx_wr       <= '0;
            tx_rd       <= '0;
            tx_count    <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr <= tx_wr + TX_PTR_ONE;
            end
            if (tx_pop) begin
                tx_rd <= tx_rd + TX_PTR_ONE;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + TX_CNT_ONE;
                2'b01:   tx_count <= tx_count - TX_CNT_ONE;
                default: tx_count <= tx_count;
            endcase
            if (tx_drop) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // TX FSM: uart_tx is a flop so it changes only on clock edges and drops
    // high immediately on reset.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else begin
            case (tx_state)
                ST_IDLE: begin
                    tx_cnt <= '0;
                    if (tx_pop) begin
                        tx_shift <= tx_mem[tx_rd];
                        tx_line  <= 1'b0;
                        tx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_line  <= tx_shift[0];
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_idx == IDX_LAST) begin
                            tx_line  <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            // LSB first: the next bit is the one above the
                            // bit currently on the line.
                            tx_line  <= tx_shift[1];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                            tx_idx   <= tx_idx + IDX_ONE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
                default: begin // ST_STOP
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_pop) begin
                            tx_shift <= tx_mem[tx_rd];
                            tx_line  <= 1'b0;
                            tx_state <= ST_START;
                        end else begin
                            tx_state <= ST_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign uart_tx      = tx_line;
    assign tx_state_dbg = tx_state;

    // -------------------------------------------------------------------------
    // RX synchroniser: two flops, plus one more stage of history for falling
    // edge detection on the synchronised signal.
    // -------------------------------------------------------------------------
    logic rx_s1;
    logic rx_s2;
    logic rx_prev;

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // -------------------------------------------------------------------------
    // RX FSM
    // -------------------------------------------------------------------------
    logic [1:0]       rx_state;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_idx;
    logic [7:0]       rx_shift;

    logic rx_bit_end;
    logic rx_stop_sample;

    always_comb begin
        rx_bit_end     = (rx_cnt == BIT_LAST);
        rx_stop_sample = (rx_state == ST_STOP) && rx_bit_end;
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            rx_state <= ST_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
        end else begin
            case (rx_state)
                ST_IDLE: begin
                    rx_cnt <= '0;
                    // Edge, not level: after a low stop bit the line must
                    // return high before a new frame can start.
                    if (rx_prev && !rx_s2) begin
                        rx_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (rx_cnt == HALF_LAST) begin
                        rx_cnt <= '0;
                        rx_idx <= '0;
                        if (rx_s2) begin
                            rx_state <= ST_IDLE;   // false start
                        end else begin
                            rx_state <= ST_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        if (rx_idx == IDX_LAST) begin
                            rx_state <= ST_STOP;
                        end else begin
                            rx_idx <= rx_idx + IDX_ONE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
                default: begin // ST_STOP
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_state <= ST_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_ONE;
                    end
                end
            endcase
        end
    end

    assign rx_state_dbg = rx_state;

    // -------------------------------------------------------------------------
    // RX FIFO and registered head view
    // -------------------------------------------------------------------------
    logic [7:0]               rx_mem [RX_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] rx_wr;
    logic [RX_DEPTH_LOG2-1:0] rx_rd;
    logic [RX_CW-1:0]         rx_count;

    logic                     rx_pop;
    logic                     rx_full;
    logic                     rx_push;
    logic                     rx_accept;
    logic                     rx_drop;
    logic [RX_CW-1:0]         rx_left;
    logic [RX_CW-1:0]         rx_count_next;
    logic [RX_DEPTH_LOG2-1:0] rx_rd_next;
    logic [7:0]               rx_head_next;

    always_comb begin
        rx_pop        = sys_tookdata && (rx_count != '0);
        rx_full       = (rx_count == RX_FULL_CNT);
        rx_push       = rx_stop_sample && rx_s2;
        // The pop is taken first, so a full FIFO popped on this edge accepts.
        rx_accept     = rx_push && (!rx_full || rx_pop);
        rx_drop       = rx_push && rx_full && !rx_pop;
        rx_left       = rx_pop ? (rx_count - RX_CNT_ONE) : rx_count;
        rx_count_next = rx_accept ? (rx_left + RX_CNT_ONE) : rx_left;
        rx_rd_next    = rx_pop ? (rx_rd + RX_PTR_ONE) : rx_rd;
        // Next head: nothing, the byte being written into an otherwise empty
        // FIFO (not yet in memory), or the stored entry at the new read slot.
        if (rx_count_next == '0) begin
            rx_head_next = 8'h00;
        end else if (rx_left == '0) begin
            rx_head_next = rx_shift;
        end else begin
            rx_head_next = rx_mem[rx_rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rx_accept) begin
            rx_mem[rx_wr] <= rx_shift;
        end
    end

    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            rx_wr        <= '0;
            rx_rd        <= '0;
            rx_count     <= '0;
            sys_idata    <= '0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_accept) begin
                rx_wr <= rx_wr + RX_PTR_ONE;
            end
            rx_rd     <= rx_rd_next;
            rx_count  <= rx_count_next;
            sys_idata <= {(rx_count_next != '0), rx_head_next};
            if (rx_drop) begin
                rx_overrun <= 1'b1;
            end
            if (rx_stop_sample && !rx_s2) begin
                rx_frame_err <= 1'b1;
            end
        end
    end

endmodule
